// File: rtl/audio_pkg.sv
// Shared audio types for the codec capture and playback paths.
package audio_pkg;

  localparam int AUDIO_WIDTH = 16;

  typedef logic signed [AUDIO_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

endpackage

// File: rtl/audio_dac_player_if.sv
// Sample-pair handshake between the DSP core (master) and the DAC player (slave).
interface audio_dac_player_if
  import audio_pkg::*;
#(
  parameter int WIDTH = AUDIO_WIDTH
) ();

  logic [WIDTH-1:0] i_left;
  logic [WIDTH-1:0] i_right;
  logic             i_valid;
  logic             o_ready;

  modport master (output i_left, output i_right, output i_valid, input o_ready);
  modport slave  (input i_left, input i_right, input i_valid, output o_ready);

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; push while full and pop while
// empty are ignored so callers may present requests unconditionally.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DW    = 2 * AUDIO_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DW-1:0]            i_data,
  output logic [DW-1:0]            o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_level = r_wrPtr - r_rdPtr;
  assign o_data  = r_mem[r_rdPtr[AW-1:0]];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointer advance; reset empties the FIFO without touching storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage write; contents are only meaningful below the write pointer.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/audio_dac_player.sv
// I2S / left-justified serializer for the WM8731 DAC, following codec DACLRCK.
module audio_dac_player
  import audio_pkg::*;
#(
  parameter int WIDTH     = AUDIO_WIDTH,
  parameter int DEPTH     = 4,
  parameter int I2S_DELAY = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_lrc,
  input  logic                    i_enable,
  audio_dac_player_if.slave       io_sample,
  output logic                    o_dacdat,
  output logic                    o_underrun,
  output logic [7:0]              o_underrun_cnt,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int SW = WIDTH + I2S_DELAY;

  logic               r_lrcQ;
  logic [SW-1:0]      r_shifter;
  logic [WIDTH-1:0]   r_rightHold;
  logic               r_dacdat;
  logic               r_underrun;
  logic [7:0]         r_underrunCnt;

  logic               w_lStart;
  logic               w_rStart;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic [2*WIDTH-1:0] w_popData;
  logic [WIDTH-1:0]   w_popLeft;
  logic [WIDTH-1:0]   w_popRight;
  logic [SW-1:0]      w_shiftNext;
  logic [WIDTH-1:0]   w_holdNext;
  logic               w_underrunNext;

  assign w_lStart        = r_lrcQ & ~i_lrc;
  assign w_rStart        = ~r_lrcQ & i_lrc;
  assign w_pop           = w_lStart & i_enable & ~w_empty;
  assign w_popLeft       = w_popData[2*WIDTH-1:WIDTH];
  assign w_popRight      = w_popData[WIDTH-1:0];
  assign io_sample.o_ready = ~w_full;
  assign o_dacdat        = r_dacdat;
  assign o_underrun      = r_underrun;
  assign o_underrun_cnt  = r_underrunCnt;

  sample_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (io_sample.i_valid),
    .i_pop   (w_pop),
    .i_data  ({io_sample.i_left, io_sample.i_right}),
    .o_data  (w_popData),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  // Next shifter/right-hold contents: reload on a channel start, otherwise shift out.
  always_comb begin
    w_shiftNext    = {r_shifter[SW-2:0], 1'b0};
    w_holdNext     = r_rightHold;
    w_underrunNext = 1'b0;
    if (w_lStart) begin
      if (w_pop) begin
        w_shiftNext = SW'(w_popLeft);
        w_holdNext  = w_popRight;
      end else begin
        w_shiftNext    = '0;
        w_holdNext     = '0;
        w_underrunNext = i_enable;
      end
    end else if (w_rStart) begin
      w_shiftNext = SW'(r_rightHold);
    end
  end

  // Serializer state, output bit and saturating underrun statistics.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lrcQ        <= i_lrc;
      r_shifter     <= '0;
      r_rightHold   <= '0;
      r_dacdat      <= 1'b0;
      r_underrun    <= 1'b0;
      r_underrunCnt <= '0;
    end else begin
      r_lrcQ      <= i_lrc;
      r_shifter   <= w_shiftNext;
      r_rightHold <= w_holdNext;
      r_dacdat    <= r_shifter[SW-1];
      r_underrun  <= w_underrunNext;
      if (w_underrunNext && (r_underrunCnt != 8'hFF)) begin
        r_underrunCnt <= r_underrunCnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_player.sv
// Bench for audio_dac_player: I2S and left-justified instances share stimulus
// and are compared every cycle against a frame-level playback model.
module tb_audio_dac_player;
  import audio_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lrc = 1'b1;
  logic             enable = 1'b0;
  logic             valid = 1'b0;
  logic [WIDTH-1:0] left = '0;
  logic [WIDTH-1:0] right = '0;

  logic             dacA, dacB, urA, urB;
  logic [7:0]       cntA, cntB;
  logic [LW-1:0]    lvlA, lvlB;

  always #5 clk = ~clk;

  audio_dac_player_if #(.WIDTH(WIDTH)) busA ();
  audio_dac_player_if #(.WIDTH(WIDTH)) busB ();

  assign busA.i_left  = left;
  assign busA.i_right = right;
  assign busA.i_valid = valid;
  assign busB.i_left  = left;
  assign busB.i_right = right;
  assign busB.i_valid = valid;

  audio_dac_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .I2S_DELAY(1)) dutI2s (
    .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_enable(enable), .io_sample(busA),
    .o_dacdat(dacA), .o_underrun(urA), .o_underrun_cnt(cntA), .o_level(lvlA)
  );

  audio_dac_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .I2S_DELAY(0)) dutLj (
    .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_enable(enable), .io_sample(busB),
    .o_dacdat(dacB), .o_underrun(urB), .o_underrun_cnt(cntB), .o_level(lvlB)
  );

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of pairs, the word of the current channel slot and
  // how many edges have passed since that slot started.
  stereo_t          mq[$];
  logic             mPrevLrc = 1'b1;
  logic [WIDTH-1:0] mWord = '0;
  logic [WIDTH-1:0] mHold = '0;
  int               mAge = 0;
  bit               mEv = 1'b0;
  logic             mUnder = 1'b0;
  int               mCnt = 0;
  logic             mOutA = 1'b0;
  logic             mOutB = 1'b0;

  logic [63:0]      capA = '0;
  logic [63:0]      capB = '0;
  int               urPulses = 0;
  int               phase = 0;

  function automatic logic slotBit(input logic [WIDTH-1:0] w, input int age, input int dly);
    if (age < dly || age >= dly + WIDTH) return 1'b0;
    return w[WIDTH-1-(age-dly)];
  endfunction

  task automatic stepCycle();
    int sz;
    bit ls, rs;
    stereo_t p;
    if (rst) begin
      mq.delete();
      mPrevLrc = lrc;
      mEv = 1'b0; mAge = 0; mWord = '0; mHold = '0;
      mUnder = 1'b0; mCnt = 0; mOutA = 1'b0; mOutB = 1'b0;
    end else begin
      sz = mq.size();
      ls = mPrevLrc && !lrc;
      rs = !mPrevLrc && lrc;
      mOutA = mEv ? slotBit(mWord, mAge, 1) : 1'b0;
      mOutB = mEv ? slotBit(mWord, mAge, 0) : 1'b0;
      if (mEv) mAge++;
      mUnder = 1'b0;
      if (ls) begin
        if (enable && sz > 0) begin
          p = mq.pop_front();
          mWord = p.left;
          mHold = p.right;
        end else begin
          mWord = '0;
          mHold = '0;
          if (enable) begin
            mUnder = 1'b1;
            if (mCnt < 255) mCnt++;
          end
        end
        mEv = 1'b1; mAge = 0;
      end else if (rs) begin
        mWord = mHold;
        mEv = 1'b1; mAge = 0;
      end
      if (valid && sz < DEPTH) mq.push_back('{left: left, right: right});
      mPrevLrc = lrc;
    end
    @(posedge clk);
    @(negedge clk);
    capA = {capA[62:0], dacA};
    capB = {capB[62:0], dacB};
    urPulses += int'(urA);
    checkOutput("dacdat_i2s", dacA, mOutA);
    checkOutput("dacdat_lj", dacB, mOutB);
    checkOutput("underrun", urA, mUnder);
    checkOutput("underrun_lj", urB, mUnder);
    checkOutput("underrun_cnt", cntA, mCnt);
    checkOutput("underrun_cnt_lj", cntB, mCnt);
    checkOutput("level", lvlA, mq.size());
    checkOutput("level_lj", lvlB, mq.size());
    checkOutput("ready", busA.o_ready, mq.size() < DEPTH);
    checkOutput("ready_lj", busB.o_ready, mq.size() < DEPTH);
  endtask

  task automatic applyStimulus(input int n, input int half, input int validPct);
    for (int i = 0; i < n; i++) begin
      if (half > 0) begin
        if (phase >= half) begin
          lrc = ~lrc;
          phase = 0;
        end
        phase++;
      end
      valid = ($urandom_range(99) < validPct);
      left  = WIDTH'($urandom);
      right = WIDTH'($urandom);
      stepCycle();
    end
    valid = 1'b0;
  endtask

  task automatic waitLrcFall();
    for (int i = 0; i < 200 && lrc != 1'b1; i++) applyStimulus(1, 32, 0);
    for (int i = 0; i < 200 && lrc != 1'b0; i++) applyStimulus(1, 32, 0);
    checkOutput("lrc_fall_wait", lrc, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
  endtask

  initial begin
    // reset values
    rst = 1'b1; lrc = 1'b1;
    repeat (3) stepCycle();
    checkOutput("rst_ready", busA.o_ready, 1);
    checkOutput("rst_level", lvlA, 0);
    checkOutput("rst_dacdat", dacA, 0);
    rst = 1'b0;
    repeat (2) stepCycle();

    // basic playback of one known pair
    enable = 1'b1;
    left = 16'hA5C3; right = 16'h8001; valid = 1'b1;
    stepCycle();
    valid = 1'b0;
    phase = 0;
    applyStimulus(50, 32, 0);
    checkOutput("basic_left", capA[16:0], 17'h0A5C3);
    checkOutput("basic_left_lj", capB[16:1], 16'hA5C3);
    applyStimulus(32, 32, 0);
    checkOutput("basic_right", capA[16:0], 17'h08001);
    checkOutput("basic_right_lj", capB[16:1], 16'h8001);
    checkOutput("basic_no_underrun", cntA, 0);

    // underrun over three frames, then saturation
    urPulses = 0;
    applyStimulus(192, 32, 0);
    checkOutput("underrun_pulses3", urPulses, 3);
    checkOutput("underrun_cnt3", cntA, 3);
    applyStimulus(2400, 4, 0);
    checkOutput("underrun_sat", cntA, 255);

    // backpressure with lrc idle, then drain in order
    doReset();
    applyStimulus(8, 0, 100);
    checkOutput("full_level", lvlA, DEPTH);
    checkOutput("full_ready", busA.o_ready, 0);
    phase = 0;
    applyStimulus(64 * 5, 32, 0);

    // mute with two pairs queued, then enable mid-frame
    doReset();
    enable = 1'b0;
    applyStimulus(2, 0, 100);
    applyStimulus(128, 32, 0);
    checkOutput("mute_level", lvlA, 2);
    checkOutput("mute_no_underrun", cntA, 0);
    waitLrcFall();
    applyStimulus(5, 32, 0);
    enable = 1'b1;
    stepCycle();
    checkOutput("mute_enable_level", lvlA, 2);
    applyStimulus(99, 32, 0);
    checkOutput("mute_resume_level", lvlA, 1);

    // reset in the middle of a left word
    doReset();
    enable = 1'b1;
    applyStimulus(1, 0, 100);
    waitLrcFall();
    applyStimulus(9, 32, 0);
    rst = 1'b1;
    stepCycle();
    checkOutput("midrst_dacdat", dacA, 0);
    checkOutput("midrst_level", lvlA, 0);
    rst = 1'b0;
    urPulses = 0;
    applyStimulus(5, 0, 0);
    checkOutput("midrst_no_event", urPulses, 0);

    // randomized frames, rates, enables and occasional resets
    for (int blk = 0; blk < 20; blk++) begin
      enable = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) doReset();
      applyStimulus(200, $urandom_range(3, 40), $urandom_range(5, 60));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_dac_player.md
Name: audio_dac_player

Overview:
Playback-side counterpart of the codec ADC capture path. It accepts parallel stereo sample pairs from the DSP/EQ core through a valid/ready handshake and buffers them in a small FIFO. It serializes each pair MSB-first onto the WM8731 DACDAT line in I2S format, following the codec-mastered DACLRCK. It runs entirely in the AUD_BCLK domain and is instantiated inside top, driving DACDAT.

Parameters:
WIDTH, 16, bits per channel sample.
DEPTH, 4, FIFO depth in stereo pairs; power of 2, at least 2.
I2S_DELAY, 1, zero BCLK slots between a DACLRCK edge and the MSB; 0 selects left-justified format.

Ports:
i_clk  in  1  AUD_BCLK; all logic on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_lrc  in  1  DACLRCK from codec; 0 = left channel, 1 = right channel.
i_enable  in  1  playback enable; 0 = mute/pause.
i_left  in  WIDTH  left sample, two's complement.
i_right  in  WIDTH  right sample, two's complement.
i_valid  in  1  sample pair present on i_left/i_right.
o_ready  out  1  FIFO can accept a pair.
o_dacdat  out  1  serial data to the codec.
o_underrun  out  1  one-cycle pulse; a frame started with the FIFO empty.
o_underrun_cnt  out  8  saturating underrun count.
o_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: o_dacdat=0, o_underrun=0, o_underrun_cnt=0, o_level=0, o_ready=1. Reset also clears the shifter, bit counter and right-hold register, and loads lrc_q with i_lrc so no event fires on the first cycle after reset.
- Reset mid-operation discards FIFO contents and any partially shifted word.
- Edge detection: lrc_q is i_lrc registered. L-start is lrc_q=1 and i_lrc=0. R-start is lrc_q=0 and i_lrc=1.
- Push: a pair is accepted when i_valid and o_ready are both high. o_ready = !full, computed from the current state and not combinationally from the pop. A push while full is ignored.
- Pop: occurs on an L-start when i_enable=1 and the FIFO is non-empty.
- Simultaneous push and pop leaves o_level unchanged. At the full boundary, a simultaneous pop does not raise o_ready that cycle.
- On L-start:
  - If popped: the shifter loads {I2S_DELAY zeros, left}, and the right-hold register loads right.
  - If i_enable=1 and the FIFO is empty: the shifter and right-hold load zeros, o_underrun pulses the next cycle, and o_underrun_cnt increments, saturating at 255.
  - If i_enable=0: zeros are loaded, with no underrun and no pop.
- On R-start: the shifter loads {I2S_DELAY zeros, right-hold}. The right-hold register is 0 if no L-start has occurred since reset.
- Shifter:
  - Width is WIDTH+I2S_DELAY. o_dacdat is the registered shifter MSB.
  - On each cycle without an event, the shifter shifts left and fills with 0.
  - After the event edge, o_dacdat is 0 for I2S_DELAY cycles, then shows the MSB through the LSB over WIDTH cycles, then stays 0 until the next event.
- Short frame: if a new event arrives before the word finishes, the shifter reloads; the old word is truncated and no error is flagged.
- Long frame: the channel is padded with zeros.
- i_enable changes take effect only at the next L-start; the frame in progress completes.
- Latency: a pair pushed into an empty FIFO appears starting at the first L-start detected after the push cycle. That is the MSB at detection edge + I2S_DELAY + 1.

Decomposition:
- audio_pkg holds: AUDIO_WIDTH=16, typedef sample_t (logic signed [AUDIO_WIDTH-1:0]), and typedef struct stereo_t {sample_t left; sample_t right;}. These are shared with the ADC capture block and top.
- Sub-module sample_fifo holds the synchronous FIFO:
  - Parameters: data width and DEPTH.
  - Ports: push, pop, full, empty, level.
  - Pointers are DEPTH-wrapping with an extra wrap bit.
  - audio_dac_player instantiates it with width 2*WIDTH.

Test Plan:
- Basic playback: i_lrc toggles every 32 clocks, push L=16'hA5C3, R=16'h8001, i_enable=1 -> the left slot shows 0 then 1010010111000011 then zeros, the right slot shows 0 then 1000000000000001, o_underrun stays 0.
- Underrun: i_enable=1, no pushes for 3 frames -> o_dacdat=0 throughout, 3 single-cycle o_underrun pulses, o_underrun_cnt=3. Hold 300 frames -> count saturates at 255.
- Full/backpressure: i_valid held high with lrc idle -> exactly DEPTH=4 pairs accepted, o_ready=0, o_level=4. The next L-start pops one pair; o_ready returns next cycle; order is preserved over frames 1-4.
- Mute: i_enable=0 with 2 pairs queued -> zero output, o_level stays 2, no underrun. Raise i_enable mid-frame -> playback starts at the next L-start, not the current frame.
- Reset mid-word: assert i_rst at bit 7 of the left word -> next cycle o_dacdat=0 and o_level=0. No event fires when i_lrc is already low after reset release.
- Format/short frame: I2S_DELAY=0 -> MSB on the first cycle after the event edge. i_lrc toggles every 8 clocks -> only the top 8 bits are output per channel, with no hang.
